// File: rtl/exec_alu_csr_pc.sv
// Execute-stage datapath: combinational ALU, machine-mode CSR file with ecall capture,
// and the PC register with branch/jump/trap/mret next-PC selection.
module exec_alu_csr_pc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_data1,
    input  logic [WIDTH-1:0] alu_data2,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero_flag,
    input  logic             csr_wen,
    input  logic             csr_is_ecall,
    input  logic [11:0]      csr_addr,
    input  logic [31:0]      csr_wdata,
    input  logic [31:0]      csr_pc,
    output logic [31:0]      csr_rdata,
    output logic [31:0]      mtvec,
    output logic [31:0]      mepc,
    input  logic             pc_valid,
    input  logic [1:0]       pc_sel,
    input  logic             pc_adder_left_sel,
    input  logic             is_branch,
    input  logic [31:0]      inst,
    input  logic [31:0]      rs1,
    input  logic [31:0]      imm,
    output logic [31:0]      pc
);
    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MVENDORID = 12'hF11;
    localparam logic [11:0] A_MARCHID   = 12'hF12;
    localparam logic [31:0] PC_RESET    = 32'h8000_0000;

    logic [31:0] r_mstatus, r_mtvec, r_mepc, r_mcause, r_pc;
    logic [31:0] w_pc_next, w_jump_sum;
    logic [4:0]  w_shamt;
    logic        w_less, w_taken;
    logic        w_unused_inst;

    // ALU
    assign w_shamt = alu_data2[4:0];
    always_comb begin
        alu_result = '0;
        case (alu_op)
            4'd0:  alu_result = alu_data1 + alu_data2;
            4'd1:  alu_result = alu_data1 - alu_data2;
            4'd2:  alu_result = alu_data1 << w_shamt;
            4'd3:  alu_result = {{(WIDTH-1){1'b0}}, $signed(alu_data1) < $signed(alu_data2)};
            4'd4:  alu_result = {{(WIDTH-1){1'b0}}, alu_data1 < alu_data2};
            4'd5:  alu_result = alu_data1 ^ alu_data2;
            4'd6:  alu_result = alu_data1 >> w_shamt;
            4'd7:  alu_result = $signed(alu_data1) >>> w_shamt;
            4'd8:  alu_result = alu_data1 | alu_data2;
            4'd9:  alu_result = alu_data1 & alu_data2;
            4'd10: alu_result = alu_data2;
            default: alu_result = '0;
        endcase
    end
    assign zero_flag = (alu_result == '0);
    assign w_less    = alu_result[0];

    // CSR file; the ecall assignment comes last so it overrides a same-cycle mepc/mcause write
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mstatus <= 32'h0000_1800;
            r_mtvec   <= '0;
            r_mepc    <= '0;
            r_mcause  <= '0;
        end else begin
            if (csr_wen) begin
                case (csr_addr)
                    A_MSTATUS: r_mstatus <= csr_wdata;
                    A_MTVEC:   r_mtvec   <= csr_wdata;
                    A_MEPC:    r_mepc    <= csr_wdata;
                    A_MCAUSE:  r_mcause  <= csr_wdata;
                    default:   ;
                endcase
            end
            if (csr_is_ecall) begin
                r_mepc   <= csr_pc;
                r_mcause <= 32'd11;
            end
        end
    end

    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            A_MSTATUS:   csr_rdata = r_mstatus;
            A_MTVEC:     csr_rdata = r_mtvec;
            A_MEPC:      csr_rdata = r_mepc;
            A_MCAUSE:    csr_rdata = r_mcause;
            A_MVENDORID: csr_rdata = 32'h7973_7978;
            A_MARCHID:   csr_rdata = 32'h0170_E5AB;
            default:     csr_rdata = '0;
        endcase
    end
    assign mtvec = r_mtvec;
    assign mepc  = r_mepc;

    // PC: branch condition resolved from the ALU flags of the compare op
    always_comb begin
        w_taken = 1'b0;
        case (inst[14:12])
            3'b000:          w_taken = zero_flag;
            3'b001:          w_taken = ~zero_flag;
            3'b100, 3'b110:  w_taken = w_less;
            3'b101, 3'b111:  w_taken = ~w_less;
            default:         w_taken = 1'b0;
        endcase
    end
    assign w_unused_inst = ^{inst[31:15], inst[11:0]};
    assign w_jump_sum    = (pc_adder_left_sel ? rs1 : r_pc) + imm;

    always_comb begin
        w_pc_next = r_pc + 32'd4;
        case (pc_sel)
            2'b00: w_pc_next = (is_branch && w_taken) ? r_pc + imm : r_pc + 32'd4;
            2'b01: w_pc_next = w_jump_sum & ~32'd1;
            2'b10: w_pc_next = r_mtvec;
            2'b11: w_pc_next = r_mepc;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)           r_pc <= PC_RESET;
        else if (pc_valid) r_pc <= w_pc_next;
    end
    assign pc = r_pc;
endmodule

// File: tb/tb_exec_alu_csr_pc.sv
// Directed bench: table-driven ALU vectors plus hand-written CSR / PC sequences.
module tb_exec_alu_csr_pc;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  alu_op;
    logic [31:0] alu_data1, alu_data2, alu_result;
    logic        zero_flag;
    logic        csr_wen, csr_is_ecall;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata, csr_pc, csr_rdata, mtvec, mepc;
    logic        pc_valid;
    logic [1:0]  pc_sel;
    logic        pc_adder_left_sel, is_branch;
    logic [31:0] inst, rs1, imm, pc;

    int nvec = 0;
    int nerr = 0;

    exec_alu_csr_pc #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .alu_op(alu_op), .alu_data1(alu_data1), .alu_data2(alu_data2),
        .alu_result(alu_result), .zero_flag(zero_flag),
        .csr_wen(csr_wen), .csr_is_ecall(csr_is_ecall), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .csr_pc(csr_pc), .csr_rdata(csr_rdata),
        .mtvec(mtvec), .mepc(mepc),
        .pc_valid(pc_valid), .pc_sel(pc_sel), .pc_adder_left_sel(pc_adder_left_sel),
        .is_branch(is_branch), .inst(inst), .rs1(rs1), .imm(imm), .pc(pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zf;
    } alu_vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; alu_op = 4'd0; alu_data1 = '0; alu_data2 = '0;
        csr_wen = 1'b0; csr_is_ecall = 1'b0; csr_addr = '0; csr_wdata = '0; csr_pc = '0;
        pc_valid = 1'b0; pc_sel = 2'b00; pc_adder_left_sel = 1'b0; is_branch = 1'b0;
        inst = '0; rs1 = '0; imm = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic rd(input string nm, input logic [11:0] a, input logic [31:0] exp);
        csr_addr = a;
        #1;
        chk(nm, csr_rdata, exp);
    endtask

    task automatic branch(input string nm, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [2:0] f3, input logic br,
                          input logic [31:0] im, input logic [31:0] exp);
        do_reset();
        alu_op = op; alu_data1 = a; alu_data2 = b;
        inst = {17'd0, f3, 12'd0}; is_branch = br; imm = im;
        pc_sel = 2'b00; pc_valid = 1'b1;
        tick();
        idle();
        chk(nm, pc, exp);
    endtask

    alu_vec_t vecs[15];

    initial begin
        vecs[0]  = '{4'd0,  32'hFFFFFFF0, 32'h4, 32'hFFFFFFF4, 1'b0};
        vecs[1]  = '{4'd1,  32'hFFFFFFF0, 32'h4, 32'hFFFFFFEC, 1'b0};
        vecs[2]  = '{4'd2,  32'hFFFFFFF0, 32'h4, 32'hFFFFFF00, 1'b0};
        vecs[3]  = '{4'd3,  32'hFFFFFFF0, 32'h4, 32'h1,        1'b0};
        vecs[4]  = '{4'd4,  32'hFFFFFFF0, 32'h4, 32'h0,        1'b1};
        vecs[5]  = '{4'd5,  32'hFFFFFFF0, 32'h4, 32'hFFFFFFF4, 1'b0};
        vecs[6]  = '{4'd6,  32'hFFFFFFF0, 32'h4, 32'h0FFFFFFF, 1'b0};
        vecs[7]  = '{4'd7,  32'hFFFFFFF0, 32'h4, 32'hFFFFFFFF, 1'b0};
        vecs[8]  = '{4'd8,  32'hFFFFFFF0, 32'h4, 32'hFFFFFFF4, 1'b0};
        vecs[9]  = '{4'd9,  32'hFFFFFFF0, 32'h4, 32'h0,        1'b1};
        vecs[10] = '{4'd10, 32'hFFFFFFF0, 32'h4, 32'h4,        1'b0};
        vecs[11] = '{4'd15, 32'hFFFFFFF0, 32'h4, 32'h0,        1'b1};
        vecs[12] = '{4'd11, 32'h12345678, 32'h1, 32'h0,        1'b1};
        vecs[13] = '{4'd0,  32'hFFFFFFFF, 32'h1, 32'h0,        1'b1};
        vecs[14] = '{4'd7,  32'h80000000, 32'h3F, 32'hFFFFFFFF, 1'b0};

        idle();
        for (int i = 0; i < 15; i++) begin
            alu_op = vecs[i].op; alu_data1 = vecs[i].a; alu_data2 = vecs[i].b;
            #1;
            chk($sformatf("alu[%0d] result", i), alu_result, vecs[i].res);
            chk($sformatf("alu[%0d] zero", i), {31'd0, zero_flag}, {31'd0, vecs[i].zf});
        end

        // Reset state
        do_reset();
        chk("rst pc", pc, 32'h80000000);
        chk("rst mtvec", mtvec, 32'h0);
        chk("rst mepc", mepc, 32'h0);
        rd("rst mstatus", 12'h300, 32'h00001800);
        rd("rst marchid", 12'hF12, 32'h0170E5AB);
        rd("rst mvendorid", 12'hF11, 32'h79737978);
        rd("rst mcause", 12'h342, 32'h0);
        rd("unimpl read", 12'h123, 32'h0);

        // mtvec write; read shows pre-write value during the write cycle
        csr_wen = 1'b1; csr_addr = 12'h305; csr_wdata = 32'h80000100;
        #1;
        chk("mtvec prewrite rdata", csr_rdata, 32'h0);
        tick();
        csr_wen = 1'b0;
        chk("mtvec write", mtvec, 32'h80000100);

        csr_is_ecall = 1'b1; csr_pc = 32'h80000020;
        tick();
        csr_is_ecall = 1'b0;
        chk("ecall mepc", mepc, 32'h80000020);
        rd("ecall mcause", 12'h342, 32'd11);

        // Trap with a same-cycle mtvec write: pc takes the old mtvec
        pc_valid = 1'b1; pc_sel = 2'b10;
        csr_wen = 1'b1; csr_addr = 12'h305; csr_wdata = 32'hDEAD0000;
        tick();
        chk("trap pc", pc, 32'h80000100);
        chk("trap mtvec wr", mtvec, 32'hDEAD0000);
        pc_sel = 2'b11; csr_addr = 12'h341; csr_wdata = 32'h00005555;
        tick();
        idle();
        chk("mret pc", pc, 32'h80000020);
        chk("mret mepc wr", mepc, 32'h00005555);

        // Read-only and unimplemented writes are dropped; mstatus is writable
        csr_wen = 1'b1; csr_addr = 12'hF11; csr_wdata = 32'h0;
        tick();
        csr_addr = 12'h7C0; csr_wdata = 32'hFF;
        tick();
        csr_addr = 12'h300; csr_wdata = 32'h0000ABCD;
        tick();
        csr_wen = 1'b0;
        rd("ro mvendorid", 12'hF11, 32'h79737978);
        rd("unimpl after wr", 12'h7C0, 32'h0);
        rd("mstatus wr", 12'h300, 32'h0000ABCD);

        // ecall vs. same-cycle writes
        csr_is_ecall = 1'b1; csr_pc = 32'h80000444;
        csr_wen = 1'b1; csr_addr = 12'h341; csr_wdata = 32'h1234;
        tick();
        chk("ecall+mepc wr", mepc, 32'h80000444);
        csr_pc = 32'h80000888; csr_addr = 12'h305; csr_wdata = 32'h200;
        tick();
        chk("ecall+mtvec wr mtvec", mtvec, 32'h200);
        chk("ecall+mtvec wr mepc", mepc, 32'h80000888);
        csr_pc = 32'h80000999; csr_addr = 12'h342; csr_wdata = 32'h7;
        tick();
        idle();
        rd("ecall+mcause wr", 12'h342, 32'd11);

        // Reset mid-operation beats pc_valid and csr_wen
        pc_valid = 1'b1; pc_sel = 2'b01; imm = 32'h40;
        csr_wen = 1'b1; csr_addr = 12'h305; csr_wdata = 32'h999;
        rst = 1'b1;
        tick();
        idle();
        chk("midrst pc", pc, 32'h80000000);
        chk("midrst mtvec", mtvec, 32'h0);
        chk("midrst mepc", mepc, 32'h0);
        rd("midrst mstatus", 12'h300, 32'h00001800);
        rd("midrst mcause", 12'h342, 32'h0);

        // Branches from reset pc
        branch("beq taken", 4'd1, 32'd5, 32'd5, 3'b000, 1'b1, 32'h10, 32'h80000010);
        branch("bne not taken", 4'd1, 32'd5, 32'd5, 3'b001, 1'b1, 32'h10, 32'h80000004);
        branch("blt taken", 4'd3, 32'd1, 32'd2, 3'b100, 1'b1, 32'hFFFFFFF8, 32'h7FFFFFF8);
        branch("bge not taken", 4'd3, 32'd1, 32'd2, 3'b101, 1'b1, 32'h10, 32'h80000004);
        branch("bgeu taken", 4'd4, 32'd9, 32'd2, 3'b111, 1'b1, 32'h20, 32'h80000020);
        branch("beq not branch", 4'd1, 32'd5, 32'd5, 3'b000, 1'b0, 32'h10, 32'h80000004);
        branch("funct3 010", 4'd1, 32'd5, 32'd5, 3'b010, 1'b1, 32'h10, 32'h80000004);

        // Jumps and hold
        do_reset();
        pc_valid = 1'b1; pc_sel = 2'b01; pc_adder_left_sel = 1'b1;
        rs1 = 32'h80001003; imm = 32'h4;
        tick();
        chk("jalr", pc, 32'h80001006);
        pc_adder_left_sel = 1'b0; imm = 32'h100;
        tick();
        chk("jal", pc, 32'h80001106);
        pc_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("hold %0d", i), pc, 32'h80001106);
        end
        pc_valid = 1'b1; pc_sel = 2'b00; is_branch = 1'b0;
        tick();
        idle();
        chk("seq +4", pc, 32'h8000110A);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/exec_alu_csr_pc.md
Name: exec_alu_csr_pc

Overview:
- Execution datapath core of the multi-cycle RV32 processor, instantiated inside the execute stage. Holds three parts:
  - combinational ALU;
  - machine-mode CSR file with ecall trap capture;
  - program-counter register with branch/jump/trap/return next-PC selection.
- The ALU less flag (result bit 0) and zero flag drive branch resolution in the PC logic.

Parameters:
- WIDTH, 32, datapath width. Only 32 is required to be supported.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- alu_op  in  4  ALU operation code.
- alu_data1  in  WIDTH  ALU operand A.
- alu_data2  in  WIDTH  ALU operand B.
- alu_result  out  WIDTH  ALU result, combinational.
- zero_flag  out  1  1 when alu_result == 0.
- csr_wen  in  1  CSR write strobe.
- csr_is_ecall  in  1  ecall trap strobe.
- csr_addr  in  12  CSR address.
- csr_wdata  in  32  CSR write data.
- csr_pc  in  32  PC of the executing instruction, captured on ecall.
- csr_rdata  out  32  combinational read of csr_addr.
- mtvec  out  32  current mtvec.
- mepc  out  32  current mepc.
- pc_valid  in  1  PC update enable.
- pc_sel  in  2  next-PC source.
- pc_adder_left_sel  in  1  jump adder left operand: 0 = pc, 1 = rs1.
- is_branch  in  1  conditional-branch instruction.
- inst  in  32  current instruction; funct3 = inst[14:12].
- rs1  in  32  rs1 value.
- imm  in  32  sign-extended immediate.
- pc  out  32  current PC.

Behaviour:

ALU (purely combinational; shift amount = alu_data2[4:0]):
- 0 ADD: a+b (mod 2^32).
- 1 SUB: a-b.
- 2 SLL.
- 3 SLT: signed less-than, result 1/0.
- 4 SLTU: unsigned less-than, result 1/0.
- 5 XOR.
- 6 SRL.
- 7 SRA: arithmetic shift.
- 8 OR.
- 9 AND.
- 10 PASSB: result = b.
- 11-15: result 0.
- zero_flag = (alu_result == 0).
- less flag = alu_result[0].

CSR file:
- Implemented registers and reset values:
  - mstatus 0x300, reset 0x00001800;
  - mtvec 0x305, reset 0;
  - mepc 0x341, reset 0;
  - mcause 0x342, reset 0.
- Read-only registers:
  - mvendorid 0xF11 reads 0x79737978;
  - marchid 0xF12 reads 0x0170E5AB;
  - writes to these are ignored.
- Unimplemented addresses read 0; writes to them are ignored.
- csr_rdata is combinational from the current register state (pre-write value in the write cycle).
- csr_wen=1: the addressed register takes csr_wdata at the clock edge.
- csr_is_ecall=1: at the clock edge, mepc <= csr_pc and mcause <= 11.
- ecall and wen in the same cycle:
  - ecall has priority for mepc and mcause;
  - a write to any other implemented register still takes effect.
- mtvec and mepc outputs show current register values.
- rst clears the CSR registers to their reset values.

PC:
- Reset: pc = 0x80000000.
- pc updates only at a rising edge with pc_valid=1; otherwise it holds.
- Branch taken, by funct3:
  - 000 (BEQ): zero_flag;
  - 001 (BNE): !zero_flag;
  - 100 (BLT), 110 (BLTU): less;
  - 101 (BGE), 111 (BGEU): !less;
  - others: 0.
  - The controller issues SUB for BEQ/BNE and SLT/SLTU for the others.
- pc_sel=00: next = (is_branch & taken) ? pc+imm : pc+4.
- pc_sel=01 (jump): next = ((pc_adder_left_sel ? rs1 : pc) + imm) & ~1.
- pc_sel=10 (trap): next = mtvec, the value before any same-cycle CSR write.
- pc_sel=11 (mret): next = mepc, the value before any same-cycle CSR write.
- All PC adds wrap modulo 2^32.
- rst has priority over pc_valid in the same cycle.
- Reset mid-operation: all state returns to reset values at the next edge; no partial updates.

Test Plan:
- ALU sweep: a=0xFFFFFFF0, b=0x00000004. Required results:
  - ADD 0xFFFFFFF4; SUB 0xFFFFFFEC;
  - SLT 1; SLTU 0;
  - SRL 0x0FFFFFFF; SRA 0xFFFFFFFF; SLL 0xFFFFFF00;
  - PASSB 4;
  - op 15 gives 0 with zero_flag=1.
- Reset: hold rst 1 cycle.
  - Required: pc=0x80000000, mtvec=0, mepc=0;
  - csr_rdata@0x300 = 0x1800; @0xF12 = 0x0170E5AB.
- CSR write/ecall: write mtvec=0x80000100, then ecall with csr_pc=0x80000020.
  - Required: mepc=0x80000020, mcause (0x342) = 11.
  - pc_sel=10 with pc_valid gives pc=0x80000100.
  - pc_sel=11 then gives pc=0x80000020.
- Same-cycle ecall and write to mepc with 0x1234: mepc=csr_pc (ecall wins).
  - Same-cycle ecall and write to mtvec with 0x200: mtvec=0x200.
- Branches from pc=0x80000000:
  - BEQ with SUB of equal operands, imm=0x10: pc=0x80000010;
  - BNE with equal operands: pc=0x80000004;
  - BLT with SLT result 1, imm=-8 (0xFFFFFFF8): pc=0x7FFFFFF8.
- Jumps and hold:
  - JALR with rs1=0x80001003, imm=4, left_sel=1: pc=0x80001006;
  - JAL with left_sel=0, imm=0x100: pc = old pc + 0x100;
  - pc_valid=0 for 3 cycles: pc unchanged.
